// File: rtl/matrix_frame_arbiter.sv
// Purpose: arbitrates two 64-bit frame sources onto an 8x8 LED matrix and row-scans the latched frame.
// Latency: row/column pins lag scan state by one clock; grant/ack/frame-done update on the frame-boundary edge.
// Backpressure: none; requests are levels sampled only at frame boundaries, o_Ack confirms each latch.
module matrix_frame_arbiter #(
  parameter int ROW_DIV     = 1024,
  parameter int DEAD        = 2,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [1:0]  i_Req,
  input  logic [63:0] i_Data0,
  input  logic [63:0] i_Data1,
  input  logic        i_Blank,
  output logic [1:0]  o_Gnt,
  output logic [1:0]  o_Ack,
  output logic        o_Frame_Done,
  output logic [7:0]  o_Rows,
  output logic [7:0]  o_Columns
);

  localparam int PW = (ROW_DIV > 2) ? $clog2(ROW_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PW-1:0] P_MAX  = PW'(ROW_DIV - 1);
  localparam logic [PW-1:0] DEAD_V = PW'(DEAD);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_t;

  owner_t        owner_q, owner_d;
  logic [PW-1:0] p_q, p_d;
  logic [2:0]    r_q, r_d;
  logic [HW-1:0] h_q, h_d;
  logic          last_q, last_d;
  logic [63:0]   frame_buf_q, frame_buf_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic          done_q, done_d;
  logic [7:0]    rows_q, rows_d;
  logic [7:0]    cols_q, cols_d;

  logic tick;
  logic boundary;
  logic own_idx;
  logic blank;

  assign tick     = (p_q == P_MAX);
  assign boundary = tick && (r_q == 3'd7);
  assign own_idx  = (owner_q == OWN_1);

  // Scan counters plus the boundary-time arbitration decision and frame latch.
  always_comb begin
    p_d         = tick ? '0 : p_q + PW'(1);
    r_d         = tick ? r_q + 3'd1 : r_q;
    owner_d     = owner_q;
    h_d         = h_q;
    last_d      = last_q;
    frame_buf_d = frame_buf_q;
    gnt_d       = gnt_q;
    ack_d       = 2'b00;
    done_d      = boundary;
    if (boundary) begin
      if ((owner_q != OWN_NONE) && i_Req[own_idx]) begin
        if (h_q < H_MAX) begin
          h_d = h_q + HW'(1);
        end else if (i_Req[~own_idx]) begin
          owner_d = own_idx ? OWN_0 : OWN_1;
          h_d     = '0;
          last_d  = ~own_idx;
        end
      end else begin
        // Owner released or display idle: prefer whoever was not served last.
        h_d = '0;
        if (i_Req[~last_q]) begin
          owner_d = last_q ? OWN_0 : OWN_1;
          last_d  = ~last_q;
        end else if (i_Req[last_q]) begin
          owner_d = last_q ? OWN_1 : OWN_0;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      case (owner_d)
        OWN_0: begin
          frame_buf_d = i_Data0;
          ack_d       = 2'b01;
          gnt_d       = 2'b01;
        end
        OWN_1: begin
          frame_buf_d = i_Data1;
          ack_d       = 2'b10;
          gnt_d       = 2'b10;
        end
        default: begin
          gnt_d = 2'b00;
        end
      endcase
    end
  end

  // Row/column drive from the current scan position; dead time blanks the start of each row.
  always_comb begin
    blank  = i_Blank || (p_q < DEAD_V);
    rows_d = 8'h00;
    cols_d = 8'hFF;
    if (!blank) begin
      rows_d = 8'h01 << r_q;
      cols_d = ~frame_buf_q[{r_q, 3'b000} +: 8];
    end
  end

  // All state and outputs registered; reset blanks the matrix immediately.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      owner_q     <= OWN_NONE;
      p_q         <= '0;
      r_q         <= 3'd0;
      h_q         <= '0;
      last_q      <= 1'b1;
      frame_buf_q <= 64'd0;
      gnt_q       <= 2'b00;
      ack_q       <= 2'b00;
      done_q      <= 1'b0;
      rows_q      <= 8'h00;
      cols_q      <= 8'hFF;
    end else begin
      owner_q     <= owner_d;
      p_q         <= p_d;
      r_q         <= r_d;
      h_q         <= h_d;
      last_q      <= last_d;
      frame_buf_q <= frame_buf_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
    end
  end

  assign o_Gnt        = gnt_q;
  assign o_Ack        = ack_q;
  assign o_Frame_Done = done_q;
  assign o_Rows       = rows_q;
  assign o_Columns    = cols_q;

endmodule

// File: doc/matrix_frame_arbiter.md
# matrix_frame_arbiter

Scan controller and frame arbiter for the 8x8 LED matrix. It shares the single display between two 64-bit frame requesters, such as an LFSR pattern source and a CPU-written pattern. It latches the granted frame into a shadow buffer only at frame boundaries, then row-scans the buffer onto the matrix row/column pins with a programmable row dwell and anti-ghosting dead time. It replaces free-running counter taps as the matrix clocking source.

## Interface
Parameters:
- ROW_DIV, 1024: clocks per row dwell; legal range ≥ 2.
- DEAD, 2: blanked clocks at the start of each row; legal range 0 ≤ DEAD < ROW_DIV.
- HOLD_FRAMES, 4: minimum full scans a granted requester keeps the display while the other requester waits; legal range ≥ 1.

Ports:
- i_CLK  in  1  system clock; all state on rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_Req  in  2  i_Req[k] high = requester k wants the display; level, held while wanted.
- i_Data0  in  64  frame of requester 0; bit 8r+c = row r, column c, 1 = lit.
- i_Data1  in  64  frame of requester 1; same layout.
- i_Blank  in  1  force display dark; scan and arbitration continue.
- o_Gnt  out  2  one-hot or zero; current display owner.
- o_Ack  out  2  one-cycle pulse: requester k's data was latched this boundary.
- o_Frame_Done  out  1  one-cycle pulse per completed 8-row scan.
- o_Rows  out  8  one-hot active-high row select.
- o_Columns  out  8  active-low column drive.

## Operation
- Prescaler p counts 0..ROW_DIV-1 and wraps. A tick occurs on the edge where p == ROW_DIV-1; that edge sets p <= 0 and r <= r+1 mod 8.
- A frame boundary is a tick with r == 7. All arbitration and latching happen only on boundary edges, using i_Req sampled at that edge.
- Arbiter state is {owner: NONE/0/1, hold count h, last-served pointer L}.
- Boundary decision, in priority order:
  1. Owner k still requesting and h < HOLD_FRAMES-1: keep k, h <= h+1.
  2. Owner k still requesting, h saturated, other requester j requesting: switch to j, h <= 0, L <= j.
  3. Owner k still requesting, other requester idle: keep k, h stays saturated.
  4. Owner dropped i_Req, or owner NONE: grant the requester ≠ L if it is requesting. Otherwise grant the single requester. Otherwise go to NONE. New owner gets h <= 0, L <= new owner.
- If the result of the decision is owner k, then frame_buf <= i_Datak and o_Ack[k] pulses. If the result is NONE, frame_buf is retained and no o_Ack pulses.
- Dropping i_Req mid-frame has no effect until the next boundary. The owner's data is re-latched every boundary, so live updates appear one frame later.
- Display: with row r and byte b = frame_buf[8r+7:8r]:
  - If i_Blank is high or p < DEAD: o_Rows = 8'h00, o_Columns = 8'hFF.
  - Otherwise: o_Rows = 1<<r, o_Columns = ~b.

## Timing
- All outputs are registered.
- o_Rows and o_Columns at cycle n+1 reflect p, r, frame_buf and i_Blank at cycle n, a one-cycle latency.
- o_Gnt, o_Ack and o_Frame_Done change on the boundary edge itself. o_Ack and o_Frame_Done are high for exactly the one cycle after that edge.
- Frame period is 8·ROW_DIV clocks. The first boundary after reset occurs at clock 8·ROW_DIV.
- Reset values (asynchronous, immediate):
  - p = 0, r = 0, h = 0, L = 1 (requester 0 wins the first tie).
  - owner NONE, frame_buf = 0.
  - o_Gnt = 0, o_Ack = 0, o_Frame_Done = 0, o_Rows = 0, o_Columns = 8'hFF.
- Reset asserted mid-scan drops all outputs to their reset values within the same cycle. After release, scanning restarts at row 0 with p = 0.
- i_Req toggles between boundaries are ignored; only the level at the boundary edge matters.
- i_Blank affects display only. It never affects p, r, or arbitration.

## Test plan
Bench parameters: ROW_DIV=4, DEAD=1, HOLD_FRAMES=2; frame period is 32 clocks.

- Reset, then i_Req=2'b00 for 64 clocks.
  - o_Gnt=0 throughout; no o_Ack.
  - o_Frame_Done pulses at clocks 32 and 64.
  - o_Rows cycles 01,02,..,80, each lit for 3 clocks after 1 blank clock; o_Columns=FF throughout (buffer is 0).
- i_Req=2'b01, i_Data0=64'h8040201008040201.
  - At the first boundary: o_Gnt=01, o_Ack=01 for one cycle.
  - Next frame shows row r with o_Columns=~(1<<r), giving diagonal columns FE,FD,..,7F.
- i_Req=2'b11 from reset.
  - Grants go 01 at boundary 1, 01 at boundary 2, 10 at boundary 3, 10 at boundary 4, 01 at boundary 5.
  - Each boundary pulses the matching o_Ack.
- Owner 0 drops i_Req mid-frame 1 while i_Req[1]=1.
  - Display keeps frame 0 until the boundary, then switches to o_Gnt=10 regardless of hold count.
  - Last frame_buf is retained when both requesters drop.
- i_Blank=1 for frame 2 with owner 0.
  - o_Rows=00, o_Columns=FF for the whole frame; o_Frame_Done and o_Ack still pulse.
- Assert i_RST at clock 45 (row 3).
  - Outputs go to their reset values immediately.
  - After release, the first boundary is 32 clocks later and o_Gnt=0 until then.
